// File: rtl/mem_dump_serializer_pkg.sv
// mem_dump_serializer_pkg: shared state encoding and word geometry for the dump serializer
package mem_dump_serializer_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W = 32;
endpackage

// File: rtl/mem_dump_serializer.sv
// mem_dump_serializer: streams a snapshot of the data memory out byte-by-byte over a UART handshake
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module mem_dump_serializer
    import mem_dump_serializer_pkg::*;
#(
    parameter int N_WORDS = 32
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [WORD_W*N_WORDS-1:0] i_data_mem,
    input  logic                      i_tx_done,
    output logic                      o_tx_start,
    output logic [7:0]                o_tx_data,
    output logic                      o_busy,
    output logic                      o_done
);
    localparam int N_BYTES = BYTES_PER_WORD * N_WORDS;
    localparam int CW = $clog2(N_BYTES);
    state_t state;
    logic [CW-1:0] cnt, nxt;
    logic [CW+2:0] off;
    logic [WORD_W*N_WORDS-1:0] snap;
    logic last;
    // Bit offset of the next byte: word-major, MSB lane first, so the lane bits are inverted.
    assign nxt = cnt + 1'b1;
    assign off = {nxt ^ CW'(3), 3'b000};
    assign last = cnt == CW'(N_BYTES - 1);
`ifdef DUMP_CHECKSUM_EN
    logic [7:0] csum;
    logic ck;
`endif
    // Outputs are loaded on entry to SEND/DONE so they are high for exactly the state's cycle.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt <= '0;
            snap <= '0;
            o_tx_start <= 1'b0;
            o_tx_data <= 8'h00;
            o_busy <= 1'b0;
            o_done <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum <= 8'h00;
            ck <= 1'b0;
`endif
        end else begin
            o_tx_start <= 1'b0;
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    snap <= i_data_mem;
                    cnt <= '0;
                    state <= SEND;
                    o_busy <= 1'b1;
                    o_tx_start <= 1'b1;
                    o_tx_data <= i_data_mem[WORD_W-1 -: 8];
`ifdef DUMP_CHECKSUM_EN
                    csum <= 8'h00;
                    ck <= 1'b0;
`endif
                end
                SEND: state <= WAIT;
                WAIT: if (i_tx_done) begin
`ifdef DUMP_CHECKSUM_EN
                    csum <= csum ^ o_tx_data;
                    if (ck) begin
                        state <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        state <= SEND;
                        o_tx_start <= 1'b1;
                        ck <= last;
                        cnt <= last ? cnt : nxt;
                        o_tx_data <= last ? csum ^ o_tx_data : snap[off +: 8];
                    end
`else
                    if (last) begin
                        state <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        state <= SEND;
                        o_tx_start <= 1'b1;
                        cnt <= nxt;
                        o_tx_data <= snap[off +: 8];
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dump_serializer.sv
// tb_mem_dump_serializer: scoreboard bench with a byte-list reference model of the memory dump
module tb_mem_dump_serializer;
    localparam int NW = 32;
    localparam int W = 32 * NW;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB = 4 * NW + 1;
`else
    localparam int NB = 4 * NW;
`endif
    logic clk = 0, i_reset = 1, i_start = 0, i_tx_done = 0;
    logic [W-1:0] i_data_mem = '0;
    logic o_tx_start, o_busy, o_done;
    logic [7:0] o_tx_data;
    int checks = 0, failures = 0;
    int nstart = 0, ndone = 0, resp_idx = 0;
    bit bp = 0;
    logic [7:0] exp_q[$];

    mem_dump_serializer #(.N_WORDS(NW)) dut (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_data_mem(i_data_mem),
        .i_tx_done(i_tx_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] img);
        logic [7:0] x, b;
        x = 8'h00;
        for (int w = 0; w < NW; w++)
            for (int l = 3; l >= 0; l--) begin
                b = img[32*w + 8*l +: 8];
                exp_q.push_back(b);
                x ^= b;
            end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Monitor: every presented byte is matched against the scoreboard.
    always @(negedge clk) if (!i_reset) begin
        if (o_tx_start) begin
            nstart++;
            if (exp_q.size() == 0) check("extra_byte", o_tx_data, -1);
            else check("byte", o_tx_data, exp_q.pop_front());
        end
        if (o_done) begin
            ndone++;
            check("done_queue_empty", exp_q.size(), 0);
        end
    end

    // UART model: completes each byte 3 cycles after its start, or 50+ cycles for byte 5 under back-pressure.
    initial begin
        logic [7:0] held;
        bit ok;
        forever begin
            if (o_tx_start === 1'b1 && !i_reset) begin
                if (bp && resp_idx == 5) begin
                    held = o_tx_data;
                    ok = 1;
                    repeat (50) begin
                        @(negedge clk);
                        if (o_tx_data !== held || o_tx_start !== 1'b0 || o_busy !== 1'b1) ok = 0;
                    end
                    check("backpressure_hold", ok, 1);
                end
                repeat (3) @(negedge clk);
                i_tx_done = 1;
                @(negedge clk);
                i_tx_done = 0;
                resp_idx++;
            end else @(negedge clk);
        end
    end

    task automatic check_idle_outputs(input string name);
        check({name, "_tx_start"}, o_tx_start, 0);
        check({name, "_tx_data"}, o_tx_data, 0);
        check({name, "_busy"}, o_busy, 0);
        check({name, "_done"}, o_done, 0);
    endtask

    // mode 0: plain, 1: scramble memory after start, 2: spurious starts during dump
    task automatic run_dump(input logic [W-1:0] img, input int mode, input string name);
        int s0, d0, cyc;
        @(negedge clk);
        i_data_mem = img;
        push_exp(img);
        resp_idx = 0;
        s0 = nstart;
        d0 = ndone;
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        check({name, "_first_start"}, o_tx_start, 1);
        if (mode == 1) i_data_mem = '1;
        cyc = 0;
        while (ndone == d0 && cyc < 5000) begin
            @(negedge clk);
            i_start = (mode == 2 && cyc % 7 == 3);
            cyc++;
        end
        i_start = 0;
        check({name, "_timeout"}, cyc < 5000, 1);
        check({name, "_byte_count"}, nstart - s0, NB);
        @(negedge clk);
        check({name, "_busy_after"}, o_busy, 0);
        check({name, "_single_done"}, ndone - d0, 1);
    endtask

    function automatic logic [W-1:0] rand_img();
        logic [W-1:0] r;
        for (int w = 0; w < NW; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [W-1:0] img;
        int s0, d0, cyc;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        i_reset = 0;
        repeat (2) @(negedge clk);
        // Known image: DEADBEEF in word 0, 01234567 in the last word.
        img = '0;
        img[31:0] = 32'hDEADBEEF;
        img[W-1 -: 32] = 32'h01234567;
        run_dump(img, 0, "known");
        run_dump(rand_img(), 1, "isolation");
        bp = 1;
        run_dump(rand_img(), 0, "backpressure");
        bp = 0;
        // tx_done while idle must not start anything.
        s0 = nstart;
        repeat (4) begin
            @(negedge clk);
            i_tx_done = 1;
            @(negedge clk);
            i_tx_done = 0;
        end
        check("idle_tx_done_starts", nstart - s0, 0);
        check("idle_tx_done_busy", o_busy, 0);
        run_dump(rand_img(), 2, "ignored_start");
        // Abort after byte 10 is on the line.
        img = rand_img();
        @(negedge clk);
        i_data_mem = img;
        push_exp(img);
        resp_idx = 0;
        s0 = nstart;
        d0 = ndone;
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        cyc = 0;
        while (nstart - s0 < 11 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_byte10", nstart - s0, 11);
        i_reset = 1;
        @(negedge clk);
        check_idle_outputs("abort");
        i_reset = 0;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("abort_no_done", ndone - d0, 0);
        check("abort_idle_busy", o_busy, 0);
        run_dump(rand_img(), 0, "restart");
        run_dump(rand_img(), 0, "random");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
